// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the odd-parity helper used when framing a byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 pad plus a falling-edge strobe.
// Resets to the idle-high level so no false edge appears after reset.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pad;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, frame, ack).
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_send,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  input  logic       iPS2CLK,
  input  logic       iPS2D,
  output logic       o_ps2clk_oe,
  output logic       o_ps2d_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  // INHIBIT lasts one cycle less than the clock-low time; RTS supplies the last one.
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       edge_cnt;
  logic             d_drive;
  logic             err;
  logic             clk_level;
  logic             clk_fall;
  logic             d_level;
  logic             unused_d_fall;
  logic             timeout;

  ps2_sync_edge u_sync_clk (
    .clk   (clk),
    .rst   (rst),
    .pad   (iPS2CLK),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk   (clk),
    .rst   (rst),
    .pad   (iPS2D),
    .level (d_level),
    .fall  (unused_d_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ST_RTS) begin
      wd_cnt <= '0;
    end else if (wd_active) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout is tested before edges so a coincident device edge loses.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (i_send) state_next = ST_INHIBIT;
      ST_INHIBIT:   if (inh_cnt == INH_LAST) state_next = ST_RTS;
      ST_RTS:       state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (timeout) state_next = ST_DONE;
        else if (clk_fall && (edge_cnt == 4'd9)) state_next = ST_ACK;
      end
      ST_ACK: begin
        if (timeout) state_next = ST_DONE;
        else if (clk_fall) state_next = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timeout) state_next = ST_DONE;
        else if (clk_level && d_level) state_next = ST_DONE;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      parity_q <= 1'b0;
      inh_cnt  <= '0;
      edge_cnt <= '0;
      d_drive  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_send) begin
            data_q   <= i_data;
            parity_q <= odd_parity(i_data);
            inh_cnt  <= '0;
            edge_cnt <= '0;
            d_drive  <= 1'b0;
            err      <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_LAST) d_drive <= 1'b1;
        end
        ST_RTS: edge_cnt <= '0;
        ST_SHIFT: begin
          if (timeout) begin
            d_drive <= 1'b0;
            err     <= 1'b1;
          end else if (clk_fall) begin
            if (edge_cnt != 4'hF) edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt < 4'd8) d_drive <= ~data_q[edge_cnt[2:0]];
            else if (edge_cnt == 4'd8) d_drive <= ~parity_q;
            else d_drive <= 1'b0;
          end
        end
        ST_ACK: begin
          if (timeout) err <= 1'b1;
          else if (clk_fall) err <= d_level;
        end
        ST_WAIT_IDLE: if (timeout) err <= 1'b1;
        default: d_drive <= 1'b0;
      endcase
    end
  end

  always_comb begin
    o_busy      = (state != ST_IDLE);
    o_done      = (state == ST_DONE);
    o_error     = (state == ST_DONE) && err;
    o_ps2clk_oe = (state == ST_INHIBIT) || (state == ST_RTS);
    o_ps2d_oe   = d_drive && ((state == ST_RTS) || (state == ST_SHIFT));
  end

endmodule
